// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin front end that shares one sequential 8x8 multiplier between NUM_REQ clients.
// Optional MUL_SHARE_SIGNED_EN: two's-complement operands handled as sign/magnitude around the unsigned multiplier.
`timescale 1ns/1ps
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [15:0]          resp_product,
  input  logic                 resp_ready,
  output logic                 mul_start,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_product,
  input  logic                 mul_ready,
  output logic                 busy
);

  localparam int SW = ID_W + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [15:0]     prod_q, prod_d;
`ifdef MUL_SHARE_SIGNED_EN
  logic            sign_q, sign_d;
`endif

  logic [NUM_REQ-1:0] rotated;
  logic               grant_found;
  logic [SW-1:0]      grant_sum;
  logic [ID_W-1:0]    grant_idx;
  logic [7:0]         sel_a, sel_b;

  // Rotate the request vector so bit 0 is the pointer's requester, then take the lowest set bit.
  always_comb begin
    rotated     = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    grant_found = 1'b0;
    grant_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rotated[k]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, ptr_q} + SW'(k);
      end
    end
    if (grant_sum >= SW'(NUM_REQ)) begin
      grant_sum = grant_sum - SW'(NUM_REQ);
    end
    grant_idx = grant_sum[ID_W-1:0];

    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[8*i +: 8];
        sel_b = req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && (state_q == IDLE) && grant_found && (grant_idx == ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
`ifdef MUL_SHARE_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = START;
          id_d    = grant_idx;
          ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
`ifdef MUL_SHARE_SIGNED_EN
          // Magnitude of -128 is 8'h80, which the unsigned multiplier takes as 128.
          a_d    = sel_a[7] ? (~sel_a + 8'd1) : sel_a;
          b_d    = sel_b[7] ? (~sel_b + 8'd1) : sel_b;
          sign_d = sel_a[7] ^ sel_b[7];
`else
          a_d = sel_a;
          b_d = sel_b;
`endif
        end
      end
      // mul_ready may still be high from the previous operation here, so it is not looked at.
      START: state_d = WAIT;
      WAIT: begin
        if (mul_ready) begin
          state_d = RESP;
`ifdef MUL_SHARE_SIGNED_EN
          prod_d = sign_q ? (~mul_product + 16'd1) : mul_product;
`else
          prod_d = mul_product;
`endif
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
`ifdef MUL_SHARE_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
`ifdef MUL_SHARE_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign mul_start    = (state_q == START);
  assign resp_valid   = (state_q == RESP);
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign resp_id      = id_q;
  assign resp_product = prod_q;

endmodule
